// File: rtl/dot_product_accumulator.sv
// Dot product of one VECTOR_WIDTH pair: registered multiply, then a wide accumulator.
// Define DOT_PRODUCT_SIGNED_EN for two's-complement operands; the default is unsigned.
module dot_product_accumulator #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  in_valid,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  elem_count,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VECTOR_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0]        prod;
    logic                 prod_valid;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic                 last_elem;

`ifdef DOT_PRODUCT_SIGNED_EN
    assign a_ext    = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign b_ext    = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
    assign prod_ext = ACC_WIDTH'($signed(prod));
`else
    assign a_ext    = {{DATA_WIDTH{1'b0}}, a_in};
    assign b_ext    = {{DATA_WIDTH{1'b0}}, b_in};
    assign prod_ext = ACC_WIDTH'(prod);
`endif

    assign busy      = (state != IDLE);
    assign last_elem = in_valid && (elem_count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_elem) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (result_valid && result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Low PW bits of the extended product are the exact product in either mode
    always_ff @(posedge clk) begin
        if (rst) begin
            prod         <= '0;
            prod_valid   <= 1'b0;
            acc          <= '0;
            elem_count   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            if (prod_valid) begin
                acc <= acc + prod_ext;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        elem_count <= '0;
                        prod_valid <= 1'b0;
                    end
                end
                ACCUM: begin
                    prod_valid <= in_valid;
                    if (in_valid) begin
                        prod       <= a_ext * b_ext;
                        elem_count <= elem_count + CNT_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    prod_valid <= 1'b0;
                end
                DONE: begin
                    // First DONE cycle captures the settled sum
                    if (!result_valid) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    prod_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator with hand-computed expected sums.
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_valid;
    logic        busy;
    logic [2:0]  elem_count;
    logic [17:0] result;
    logic        result_valid;
    logic        result_ready;

    int checks = 0;
    int failures = 0;

    dot_product_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .in_valid     (in_valid),
        .busy         (busy),
        .elem_count   (elem_count),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Element i of a vector lives in byte i of the packed word
    task automatic run_vec(input string tag, input logic [31:0] av,
                           input logic [31:0] bv, input int gap,
                           input logic [31:0] exp);
        start    = 1'b1;
        in_valid = 1'b1;
        a_in     = 8'h55;
        b_in     = 8'h55;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_cnt0"}, 32'(elem_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            a_in     = av[8*i +: 8];
            b_in     = bv[8*i +: 8];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check({tag, "_cnt"}, 32'(elem_count), 32'(i + 1));
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check({tag, "_cnt_gap"}, 32'(elem_count), 32'(i + 1));
                end
            end
        end
        check({tag, "_rv_n0"}, 32'(result_valid), 32'd0);
        tick();
        check({tag, "_rv_n1"}, 32'(result_valid), 32'd0);
        tick();
        check({tag, "_rv_n2"}, 32'(result_valid), 32'd1);
        check({tag, "_result"}, 32'(result), exp);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        a_in         = '0;
        b_in         = '0;
        in_valid     = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(elem_count), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        rst = 1'b0;
        tick();

        run_vec("basic", 32'h04030201, 32'h08070605, 0, 32'd70);
        tick();
        check("basic_busy_done", 32'(busy), 32'd0);
        check("basic_rv_done", 32'(result_valid), 32'd0);
        check("basic_cnt_done", 32'(elem_count), 32'd4);

`ifdef DOT_PRODUCT_SIGNED_EN
        run_vec("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd4);
`else
        run_vec("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h3F804);
`endif
        tick();

        run_vec("gaps", 32'h04030201, 32'h08070605, 3, 32'd70);
        tick();
        check("gaps_busy_done", 32'(busy), 32'd0);

        result_ready = 1'b0;
        run_vec("bp", 32'h04030201, 32'h08070605, 0, 32'd70);
        for (int i = 0; i < 10; i++) begin
            start    = (i == 2);
            in_valid = 1'b1;
            a_in     = 8'h10;
            b_in     = 8'h10;
            tick();
            check("bp_hold_result", 32'(result), 32'd70);
            check("bp_hold_rv", 32'(result_valid), 32'd1);
            check("bp_hold_cnt", 32'(elem_count), 32'd4);
        end
        start        = 1'b0;
        in_valid     = 1'b0;
        result_ready = 1'b1;
        tick();
        check("bp_rv_drop", 32'(result_valid), 32'd0);
        check("bp_busy_drop", 32'(busy), 32'd0);
        tick();
        check("bp_idle_stays", 32'(busy), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in     = 8'd9;
            b_in     = 8'd9;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("abort_cnt_pre", 32'(elem_count), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(elem_count), 32'd0);
        check("abort_rv", 32'(result_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        run_vec("after_abort", 32'h01010101, 32'h02020202, 0, 32'd8);
        tick();

`ifdef DOT_PRODUCT_SIGNED_EN
        run_vec("sign", 32'hFFFFFFFF, 32'h02020202, 0, 32'h3FFF8);
`else
        run_vec("sign", 32'hFFFFFFFF, 32'h02020202, 0, 32'd2040);
`endif
        tick();
        check("sign_busy_done", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
